hack_pc: RTL and testbench
==========================

// Module: hack_pc
// PURPOSE
//  Program counter for the Hack CPU; consumes the 16-bit incrementer's +1 function.
//  Holds the address of the next instruction fetched from ROM.
//  Next value each cycle: reset, load, increment or hold, with fixed priority.
//  Optionally adds a small hardware call/return stack for subroutine linkage.
// PARAMETERS
//  WIDTH        16  PC / address width in bits
//  STACK_DEPTH  4   return-stack entries (power of 2, >=2); used only with PC_STACK_EN
// PORTS
//  clk        in   1                 rising-edge clock
//  rst_n      in   1                 asynchronous, active-low reset
//  in         in   WIDTH             jump / call target
//  load       in   1                 jump: PC <= in
//  inc        in   1                 advance: PC <= PC+1
//  reset      in   1                 synchronous clear (Hack reset button)
//  call       in   1                 push PC+1, PC <= in (PC_STACK_EN only)
//  ret        in   1                 pop top of stack into PC (PC_STACK_EN only)
//  out        out  WIDTH             current PC, registered
//  wrapped    out  1                 sticky: an increment went from all-ones to 0
//  stk_depth  out  clog2(DEPTH)+1    live stack entries
//  stk_err    out  1                 sticky: call when full, or ret when empty
// BEHAVIOUR
//  - rst_n low, asynchronously: out=0, wrapped=0, stk_depth=0, stk_err=0; stack contents don't-care.
//  - All updates on rising clk; out reflects the new value one cycle after the request edge.
//  - Priority per edge, highest first: reset > ret > call > load > inc > hold.
//  - reset=1: out=0, wrapped=0, stk_depth=0, stk_err=0. Same clear as rst_n, but synchronous.
//  - inc: out <= (out+1) mod 2^WIDTH, carry discarded.
//    If out was all-ones, out=0 and wrapped<=1; wrapped holds until reset or rst_n.
//  - load: out <= in. A load never sets or clears wrapped. load+inc together: load wins.
//  - hold: when no request is active, out is unchanged.
//  - Flags are sticky and set only by their own events. Inputs are sampled only at clk edges.
//  - Mid-operation reset (either kind) discards any in-flight request issued that cycle.
// CONFIGURATION
//  Macro PC_STACK_EN.
//  Defined: LIFO of STACK_DEPTH entries, each WIDTH bits.
//   - call, not full: push (out+1) mod 2^WIDTH, out<=in, depth+1.
//   - call, full: out<=in, push dropped, contents/depth unchanged, stk_err<=1.
//   - ret, not empty: out<=top, depth-1.
//   - ret, empty: out holds, stk_err<=1.
//   - call+ret same cycle: ret executes, call ignored.
//   - Pushed return address of all-ones PC wraps to 0; does not set wrapped.
//  Undefined: call and ret ports present but ignored (no load, no push/pop).
//   No stack storage; stk_depth tied 0; stk_err tied 0.
// TESTING
//  1) rst_n low with out=0x1234 -> out=0 immediately (before next clk); wrapped=0.
//  2) load=1, in=0xFFFE; then inc x2 -> out 0xFFFE, 0xFFFF, 0x0000; wrapped=1; then reset=1 -> out=0, wrapped=0.
//  3) load=1, inc=1, in=0x0005 -> out=0x0005; then inc+reset -> out=0; then idle 3 cycles -> out stays 0.
//  4) [PC_STACK_EN] out=0x0010, call in=0x0100 -> out=0x0100, depth=1; ret -> out=0x0011, depth=0.
//  5) [PC_STACK_EN] 5 calls (DEPTH=4) -> depth=4, stk_err=1, out=last in; then 4 rets -> original return addresses in LIFO order;
//     5th ret -> out holds, stk_err stays 1.
//  6) [PC_STACK_EN] call+ret same cycle with depth=1 -> pops, depth=0, no push.
//     [no macro] call=1, in=0x0200 -> out unchanged, stk_err=0, stk_depth=0.

Source files
------------

// File: rtl/hack_pc.sv
`default_nettype none
// ============================================================================
//  Module   : hack_pc
//  Purpose  : Hack CPU program counter. Each cycle the next PC is chosen with
//             fixed priority: reset > ret > call > load > inc > hold.
//             Define PC_STACK_EN to add a small LIFO return-address stack
//             that serves call/ret; without it call and ret are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module hack_pc #(
   parameter int WIDTH       = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [WIDTH-1:0]               in,
   input  logic                           load,
   input  logic                           inc,
   input  logic                           reset,
   input  logic                           call,
   input  logic                           ret,
   output logic [WIDTH-1:0]               out,
   output logic                           wrapped,
   output logic [$clog2(STACK_DEPTH):0]   stk_depth,
   output logic                           stk_err
);

   localparam int DW = $clog2(STACK_DEPTH) + 1;   // depth counter width
   localparam int AW = DW - 1;                    // stack slot index width

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_pc_inc;
   logic             r_wrapped;
   logic             w_wrap_nxt;

   // Incrementer result doubles as the return address pushed on a call.
   assign w_pc_inc = r_pc + WIDTH'(1);

`ifdef PC_STACK_EN
   logic [WIDTH-1:0] r_stack [STACK_DEPTH];
   logic [DW-1:0]    r_depth;
   logic [DW-1:0]    w_depth_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_top_idx;

   assign w_full    = (r_depth == DW'(STACK_DEPTH));
   assign w_empty   = (r_depth == '0);
   assign w_wr_idx  = r_depth[AW-1:0];
   assign w_top_idx = r_depth[AW-1:0] - AW'(1);
`else
   logic w_unused;

   // call/ret have no effect without the stack.
   assign w_unused = call ^ ret;
`endif

   // Next-state selection in priority order; lower requests are ignored.
   always_comb begin
      w_pc_nxt   = r_pc;
      w_wrap_nxt = r_wrapped;
`ifdef PC_STACK_EN
      w_depth_nxt = r_depth;
      w_err_nxt   = r_err;
      w_push      = 1'b0;
`endif
      if (reset) begin
         w_pc_nxt   = '0;
         w_wrap_nxt = 1'b0;
`ifdef PC_STACK_EN
         w_depth_nxt = '0;
         w_err_nxt   = 1'b0;
`endif
      end
`ifdef PC_STACK_EN
      else if (ret) begin
         if (w_empty) begin
            w_err_nxt = 1'b1;
         end else begin
            w_pc_nxt    = r_stack[w_top_idx];
            w_depth_nxt = r_depth - DW'(1);
         end
      end
      else if (call) begin
         w_pc_nxt = in;
         if (w_full) begin
            w_err_nxt = 1'b1;
         end else begin
            w_push      = 1'b1;
            w_depth_nxt = r_depth + DW'(1);
         end
      end
`endif
      else if (load) begin
         w_pc_nxt = in;
      end
      else if (inc) begin
         w_pc_nxt = w_pc_inc;
         if (&r_pc) begin
            w_wrap_nxt = 1'b1;
         end
      end
   end

   // PC, sticky flags and depth counter; cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= '0;
         r_wrapped <= 1'b0;
`ifdef PC_STACK_EN
         r_depth   <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_pc      <= w_pc_nxt;
         r_wrapped <= w_wrap_nxt;
`ifdef PC_STACK_EN
         r_depth   <= w_depth_nxt;
         r_err     <= w_err_nxt;
`endif
      end
   end

`ifdef PC_STACK_EN
   // Stack storage needs no reset: only slots below the depth are ever read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[w_wr_idx] <= w_pc_inc;
      end
   end

   assign stk_depth = r_depth;
   assign stk_err   = r_err;
`else
   assign stk_depth = '0;
   assign stk_err   = 1'b0;
`endif

   assign out     = r_pc;
   assign wrapped = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_hack_pc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hack_pc
//  Purpose  : Scoreboard bench for hack_pc. The driver queues the expected
//             post-edge state for every cycle it issues; a monitor pops one
//             entry per rising edge and checks the DUT on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hack_pc;

   typedef struct {
      string       name;
      logic [15:0] pc;
      logic        wr;
      logic [2:0]  dep;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in = '0;
   logic        load = 1'b0;
   logic        inc = 1'b0;
   logic        reset = 1'b0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [15:0] out;
   logic        wrapped;
   logic [2:0]  stk_depth;
   logic        stk_err;

   int   n_checks = 0;
   int   n_fails  = 0;
   exp_t q[$];

   hack_pc #(.WIDTH(16), .STACK_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .load      (load),
      .inc       (inc),
      .reset     (reset),
      .call      (call),
      .ret       (ret),
      .out       (out),
      .wrapped   (wrapped),
      .stk_depth (stk_depth),
      .stk_err   (stk_err)
   );

   always #5 clk = ~clk;

   // Single comparison point shared by monitor and direct checks.
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fails++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, expv);
      end
   endtask

   function automatic exp_t mk(input string name, input logic [15:0] pc, input logic wr,
                               input logic [2:0] dep, input logic err);
      exp_t e;
      e.name = name; e.pc = pc; e.wr = wr; e.dep = dep; e.err = err;
      return e;
   endfunction

   // Issue one cycle of requests and queue the state expected after that edge.
   task automatic step(input logic l, input logic i, input logic r, input logic c,
                       input logic rt, input logic [15:0] d, input exp_t e);
      load = l; inc = i; reset = r; call = c; ret = rt; in = d;
      q.push_back(e);
      @(posedge clk);
      #1;
      load = 1'b0; inc = 1'b0; reset = 1'b0; call = 1'b0; ret = 1'b0;
   endtask

   // Monitor: one expectation per edge, checked on the following falling edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            chk({e.name, ".out"},     out,              e.pc);
            chk({e.name, ".wrapped"}, {15'd0, wrapped}, {15'd0, e.wr});
            chk({e.name, ".depth"},   {13'd0, stk_depth}, {13'd0, e.dep});
            chk({e.name, ".err"},     {15'd0, stk_err}, {15'd0, e.err});
         end
      end
   end

   initial begin
      // Reset state
      #12;
      chk("por.out", out, 16'h0000);
      chk("por.wrapped", {15'd0, wrapped}, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1) async reset clears immediately
      step(1, 0, 0, 0, 0, 16'h1234, mk("t1_load", 16'h1234, 0, 0, 0));
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t1_async.out", out, 16'h0000);
      chk("t1_async.wrapped", {15'd0, wrapped}, 16'h0000);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 2) wrap-around, load keeps wrapped, sync reset clears
      step(1, 0, 0, 0, 0, 16'hFFFE, mk("t2_load", 16'hFFFE, 0, 0, 0));
      step(0, 1, 0, 0, 0, 16'h0000, mk("t2_inc1", 16'hFFFF, 0, 0, 0));
      step(0, 1, 0, 0, 0, 16'h0000, mk("t2_wrap", 16'h0000, 1, 0, 0));
      step(0, 1, 0, 0, 0, 16'h0000, mk("t2_inc3", 16'h0001, 1, 0, 0));
      step(1, 0, 0, 0, 0, 16'h1234, mk("t2_ldkeep", 16'h1234, 1, 0, 0));
      step(0, 0, 1, 0, 0, 16'h0000, mk("t2_reset", 16'h0000, 0, 0, 0));

      // 3) load beats inc, reset beats inc, idle holds
      step(1, 1, 0, 0, 0, 16'h0005, mk("t3_ldinc", 16'h0005, 0, 0, 0));
      step(0, 1, 1, 0, 0, 16'h0000, mk("t3_rstinc", 16'h0000, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         step(0, 0, 0, 0, 0, 16'h0000, mk("t3_idle", 16'h0000, 0, 0, 0));
      step(1, 0, 0, 0, 0, 16'h00FF, mk("t3_ld", 16'h00FF, 0, 0, 0));
      step(0, 1, 0, 0, 0, 16'h0000, mk("t3_carry", 16'h0100, 0, 0, 0));
      step(1, 0, 0, 0, 0, 16'hABCD, mk("t3_ld2", 16'hABCD, 0, 0, 0));
      step(0, 0, 0, 0, 0, 16'h5555, mk("t3_hold", 16'hABCD, 0, 0, 0));

`ifdef PC_STACK_EN
      // 4) basic call/return
      step(0, 0, 1, 0, 0, 16'h0000, mk("t4_rst", 16'h0000, 0, 0, 0));
      step(1, 0, 0, 0, 0, 16'h0010, mk("t4_ld", 16'h0010, 0, 0, 0));
      step(0, 0, 0, 1, 0, 16'h0100, mk("t4_call", 16'h0100, 0, 1, 0));
      step(0, 0, 0, 0, 1, 16'h0000, mk("t4_ret", 16'h0011, 0, 0, 0));

      // 5) overflow then drain in LIFO order, then underflow
      step(1, 0, 0, 0, 0, 16'h0020, mk("t5_ld", 16'h0020, 0, 0, 0));
      step(0, 0, 0, 1, 0, 16'h0100, mk("t5_c1", 16'h0100, 0, 1, 0));
      step(0, 0, 0, 1, 0, 16'h0200, mk("t5_c2", 16'h0200, 0, 2, 0));
      step(0, 0, 0, 1, 0, 16'h0300, mk("t5_c3", 16'h0300, 0, 3, 0));
      step(0, 0, 0, 1, 0, 16'h0400, mk("t5_c4", 16'h0400, 0, 4, 0));
      step(0, 0, 0, 1, 0, 16'h0500, mk("t5_c5", 16'h0500, 0, 4, 1));
      step(0, 0, 0, 0, 1, 16'h0000, mk("t5_r1", 16'h0301, 0, 3, 1));
      step(0, 0, 0, 0, 1, 16'h0000, mk("t5_r2", 16'h0201, 0, 2, 1));
      step(0, 0, 0, 0, 1, 16'h0000, mk("t5_r3", 16'h0101, 0, 1, 1));
      step(0, 0, 0, 0, 1, 16'h0000, mk("t5_r4", 16'h0021, 0, 0, 1));
      step(0, 0, 0, 0, 1, 16'h0000, mk("t5_r5", 16'h0021, 0, 0, 1));

      // 6) ret wins over call; all-ones return address wraps without flag
      step(0, 0, 1, 0, 0, 16'h0000, mk("t6_rst", 16'h0000, 0, 0, 0));
      step(1, 0, 0, 0, 0, 16'h0030, mk("t6_ld", 16'h0030, 0, 0, 0));
      step(0, 0, 0, 1, 0, 16'h0040, mk("t6_call", 16'h0040, 0, 1, 0));
      step(0, 0, 0, 1, 1, 16'h0050, mk("t6_both", 16'h0031, 0, 0, 0));
      step(1, 0, 0, 0, 0, 16'hFFFF, mk("t6_ldff", 16'hFFFF, 0, 0, 0));
      step(0, 0, 0, 1, 0, 16'h0060, mk("t6_callff", 16'h0060, 0, 1, 0));
      step(0, 0, 0, 0, 1, 16'h0000, mk("t6_retff", 16'h0000, 0, 0, 0));
`else
      // 6) call/ret ignored without the stack
      step(0, 0, 0, 1, 0, 16'h0200, mk("t6_call", 16'hABCD, 0, 0, 0));
      step(0, 0, 0, 0, 1, 16'h0000, mk("t6_ret", 16'hABCD, 0, 0, 0));
      step(0, 0, 0, 1, 1, 16'h0300, mk("t6_both", 16'hABCD, 0, 0, 0));
`endif

      // Let the monitor drain; a leftover entry is a failure.
      repeat (3) @(negedge clk);
      chk("drain.qsize", 16'(q.size()), 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
